switch_alloc_rr: RTL
====================

// Module: switch_alloc_rr
// PURPOSE
//  Switch allocator for the 5-port XY router. Takes the one-hot output requests from
//  the five route-compute units. Arbitrates each output port round-robin and holds
//  the grant for a whole packet (wormhole lock, head to tail). Tracks downstream
//  buffer credits per output. Drives the one-hot crossbar selects and the per-input
//  grants. Sits between compute0..4 and crossbar, replacing the stateless per-output
//  arbiters.
// PARAMETERS
//  NPORT  5   number of router ports (L=0,E=1,W=2,N=3,S=4); the RTL supports only 5
//  DEPTH  4   downstream input-buffer depth in flits, which is the initial credit count
//  CW     3   credit counter width, = $clog2(DEPTH+1)
// PORTS
//  clk        in   1        single clock, rising edge
//  rst        in   1        synchronous, active-high reset
//  req        in   NPORT*NPORT  req[i*5+o]: input i's head-of-queue flit targets output o; one-hot per input
//  vld        in   NPORT    vld[i]: input i holds a valid flit
//  tail       in   NPORT    tail[i]: input i's current flit is a tail (head==tail allowed)
//  credit_in  in   NPORT    credit_in[o]: one-cycle pulse, downstream of output o freed one slot
//  sel        out  NPORT*NPORT  sel[o*5+i]: crossbar select, one-hot or zero per output
//  gnt        out  NPORT    gnt[i]: input i's flit is transferred this cycle; input must dequeue
//  busy       out  NPORT    busy[o]: output o is locked to a packet
// BEHAVIOUR
//  - sel and gnt are combinational from the registered state and the current req, vld, tail and credits.
//    All state updates on the rising clk edge. Latency from req to grant is 0 cycles; throughput is 1 flit/cycle/output.
//  - Per-output FSM, with state {IDLE, LOCKED(owner[2:0])} and ptr[2:0] (highest-priority input):
//    IDLE: eligible(i) = vld[i] & req[i*5+o].
//      If credits[o] > 0 and any input is eligible, grant the first eligible input searching ptr, ptr+1, ... mod 5.
//      If the winner's tail=1: stay IDLE and set ptr = winner+1 mod 5.
//      Otherwise go to LOCKED(winner).
//    LOCKED(w): only w may be granted, when vld[w] & req[w*5+o] & credits[o] > 0; other inputs are ignored.
//      On a granted flit with tail[w]=1: go to IDLE and set ptr = w+1 mod 5.
//      Bubbles (vld[w]=0) or zero credits keep the lock and grant nothing.
//  - transfer[o] = (some sel[o*5+i] = 1).
//    gnt[i] = OR over o of sel[o*5+i]. Because req is one-hot per input, at most one output grants each input.
//  - Credits per output, range 0..DEPTH:
//    transfer & !credit_in decrements; !transfer & credit_in increments; both at once leaves the count unchanged.
//    credit_in at DEPTH with no transfer saturates at DEPTH; a simulation-only assertion flags it.
//    Never grant at 0 credits, so the counter never underflows.
//  - Illegal: req not one-hot for a valid input, or req with vld=0. Both are ignored by gating with vld; an assertion flags a non-one-hot req.
//  - busy[o] = 1 in LOCKED, 0 in IDLE.
//  - Reset (also applies mid-packet): every output goes to IDLE with ptr=0 and credits=DEPTH.
//    sel, gnt and busy are all 0 during and immediately after reset, because no state is locked.
//    A partially sent packet is abandoned; recovery is the system's responsibility.
// STRUCTURE
//  - Shared package noc_pkg: port index constants P_L=0, P_E=1, P_W=2, P_N=3, P_S=4.
//    It also holds NPORT and the alloc state encoding (ST_IDLE=1'b0, ST_LOCK=1'b1).
//  - One sub-module, rr_lock_arb: a single output's FSM, ptr, owner and credit counter.
//    rr_lock_arb interface: eligible[4:0], tail[4:0], credit_in -> grant[4:0], busy.
//  - The top instantiates rr_lock_arb five times and transposes req/sel. There is no other logic at the top.
// TESTING
//  1. After reset, inputs 0 and 3 both request output 2 with single-flit packets (tail=1) for 4 cycles.
//     Grants alternate 0,3,0,3 and sel[2*5+0] and sel[2*5+3] alternate.
//  2. Input 1 sends a 3-flit packet to N with a vld bubble in flit 2, while input 4 also requests N.
//     Input 4 gets no grant until input 1's tail transfers; input 4 is granted the next cycle. busy[3] is high for the packet.
//  3. DEPTH=4 and no credit_in: input 0 streams 6 flits to E.
//     Exactly 4 grants, then gnt[0]=0. One credit_in pulse gives exactly 1 more grant.
//  4. Transfer and credit_in in the same cycle on W at credits=2: credits stay 2.
//     credit_in at credits=4 with no transfer: credits stay 4 and the assertion fires.
//  5. Five inputs each send a single-flit packet to five distinct outputs in one cycle: all five gnt bits are high, each sel row is one-hot.
//  6. Assert rst while output S is LOCKED mid-packet: the next cycle busy=0, sel=0, credits=DEPTH.
//     A new head from another input is granted immediately.

Source files
------------

// File: rtl/noc_pkg.sv
// Shared router definitions: port numbering, port count and switch-allocator state encoding.
package noc_pkg;

    localparam int NPORT = 5;

    localparam int P_L = 0;
    localparam int P_E = 1;
    localparam int P_W = 2;
    localparam int P_N = 3;
    localparam int P_S = 4;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_LOCK = 1'b1
    } alloc_st_t;

    // Reduce (p mod NPORT) for p in 0..2*NPORT-2, used for round-robin pointer arithmetic.
    function automatic logic [2:0] port_wrap(input logic [3:0] p);
        return (p >= 4'(NPORT)) ? 3'(p - 4'(NPORT)) : p[2:0];
    endfunction

endpackage

// File: rtl/rr_lock_arb.sv
// One output port of the switch allocator: round-robin arbitration with a wormhole lock
// held from head to tail, plus the downstream credit counter for that output.
module rr_lock_arb
    import noc_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CW    = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NPORT-1:0] eligible,
    input  logic [NPORT-1:0] tail,
    input  logic             credit_in,
    output logic [NPORT-1:0] grant,
    output logic             busy
);

    alloc_st_t     state_reg, state_next;
    logic [2:0]    owner_reg, owner_next;
    logic [2:0]    ptr_reg, ptr_next;
    logic [CW-1:0] credits_reg, credits_next;

    logic [2:0] win;
    logic [2:0] idx;
    logic       found;
    logic       have_credit;
    logic       transfer;

    assign have_credit = (credits_reg != '0);

    // Walk downward so the candidate closest to ptr is the last one to overwrite win.
    always_comb begin
        win   = ptr_reg;
        idx   = '0;
        found = 1'b0;
        for (int k = NPORT - 1; k >= 0; k--) begin
            idx = port_wrap(4'(ptr_reg) + 4'(k));
            if (eligible[idx]) begin
                win   = idx;
                found = 1'b1;
            end
        end
    end

    always_comb begin
        grant = '0;
        if (!rst && have_credit) begin
            if (state_reg == ST_IDLE) begin
                if (found) begin
                    grant[win] = 1'b1;
                end
            end else begin
                grant[owner_reg] = eligible[owner_reg];
            end
        end
    end

    assign transfer = |grant;
    assign busy     = (state_reg == ST_LOCK) && !rst;

    always_comb begin
        state_next = state_reg;
        owner_next = owner_reg;
        ptr_next   = ptr_reg;
        if (transfer) begin
            if (state_reg == ST_IDLE) begin
                if (tail[win]) begin
                    ptr_next = port_wrap(4'(win) + 4'd1);
                end else begin
                    state_next = ST_LOCK;
                    owner_next = win;
                end
            end else if (tail[owner_reg]) begin
                state_next = ST_IDLE;
                ptr_next   = port_wrap(4'(owner_reg) + 4'd1);
            end
        end
    end

    // A freed slot arriving together with a sent flit cancels out; a surplus credit at DEPTH is dropped.
    always_comb begin
        credits_next = credits_reg;
        case ({transfer, credit_in})
            2'b10:   credits_next = credits_reg - CW'(1);
            2'b01:   credits_next = (credits_reg == CW'(DEPTH)) ? credits_reg : credits_reg + CW'(1);
            default: credits_next = credits_reg;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= ST_IDLE;
            owner_reg   <= '0;
            ptr_reg     <= '0;
            credits_reg <= CW'(DEPTH);
        end else begin
            state_reg   <= state_next;
            owner_reg   <= owner_next;
            ptr_reg     <= ptr_next;
            credits_reg <= credits_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(credit_in && !transfer && credits_reg == CW'(DEPTH)))
                else $warning("rr_lock_arb: credit returned while counter already at DEPTH");
        end
    end

endmodule

// File: rtl/switch_alloc_rr.sv
// 5-port switch allocator: one locking round-robin arbiter per output; this level only
// gates requests with vld and transposes the request / select matrices.
module switch_alloc_rr #(
    parameter int NPORT = noc_pkg::NPORT,
    parameter int DEPTH = 4,
    parameter int CW    = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NPORT*NPORT-1:0] req,
    input  logic [NPORT-1:0]       vld,
    input  logic [NPORT-1:0]       tail,
    input  logic [NPORT-1:0]       credit_in,
    output logic [NPORT*NPORT-1:0] sel,
    output logic [NPORT-1:0]       gnt,
    output logic [NPORT-1:0]       busy
);

    logic [NPORT-1:0] elig    [NPORT];
    logic [NPORT-1:0] grant_o [NPORT];
    logic [NPORT-1:0] col     [NPORT];

    for (genvar gi = 0; gi < NPORT; gi++) begin : g_out
        for (genvar gj = 0; gj < NPORT; gj++) begin : g_in
            assign elig[gi][gj]         = vld[gj] & req[gj*NPORT + gi];
            assign sel[gi*NPORT + gj]   = grant_o[gi][gj];
            assign col[gj][gi]          = grant_o[gi][gj];
        end

        rr_lock_arb #(
            .DEPTH (DEPTH),
            .CW    (CW)
        ) u_arb (
            .clk       (clk),
            .rst       (rst),
            .eligible  (elig[gi]),
            .tail      (tail),
            .credit_in (credit_in[gi]),
            .grant     (grant_o[gi]),
            .busy      (busy[gi])
        );
    end

    for (genvar gi = 0; gi < NPORT; gi++) begin : g_gnt
        assign gnt[gi] = |col[gi];

        always_ff @(posedge clk) begin
            if (!rst && vld[gi]) begin
                assert ($onehot(req[gi*NPORT +: NPORT]))
                    else $error("switch_alloc_rr: input %0d request is not one-hot", gi);
            end
        end
    end

endmodule
